regfile_wb_ctrl: RTL
====================

Name: regfile_wb_ctrl

Overview:
- Write-back controller and scoreboard for the 32-entry general-purpose register file.
- Arbitrates the single register-file write port between two write-back sources, the ALU and the memory/load unit.
- Drives the port from a registered output stage.
- Tracks pending writes per register and stalls issue on RAW/WAW hazards.

Parameters:
- REG_DATA_WIDTH_POW, 6, log2 of register data width; REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW.

Ports:
- clk_in  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- issue_valid_in  in  1  decoder presents an instruction.
- issue_rd_in  in  5  destination register of the issuing instruction.
- issue_rs1_in  in  5  source register 1.
- issue_rs2_in  in  5  source register 2.
- issue_ready_out  out  1  issue may proceed this cycle.
- alu_valid_in  in  1  ALU write-back request.
- alu_rd_in  in  5  ALU destination register.
- alu_data_in  in  REG_DATA_WIDTH  ALU result.
- alu_ready_out  out  1  ALU request granted this cycle.
- mem_valid_in  in  1  load write-back request.
- mem_rd_in  in  5  load destination register.
- mem_data_in  in  REG_DATA_WIDTH  load data.
- mem_ready_out  out  1  load request granted this cycle.
- rf_write_en_out  out  1  to register file write_en.
- rf_rd_out  out  5  to register file rd.
- rf_write_data_out  out  REG_DATA_WIDTH  to register file write data.
- busy_out  out  32  scoreboard vector; bit i set means register i has a write pending.

Behaviour:
- Reset: busy = 0, rf_write_en_out = 0, rf_rd_out = 0, rf_write_data_out = 0, RR pointer = ALU. While reset is high, issue_ready_out, alu_ready_out and mem_ready_out are 0.
- Reset takes effect mid-operation. In-flight grants are discarded and no register-file write occurs on the cycle after reset.
- Handshakes: a transfer occurs when valid && ready in the same cycle. The readies are combinational. Each source must hold valid, rd and data stable until accepted.
- Arbitration:
  - At most one grant per cycle.
  - Only one source valid: that source is granted.
  - Both valid: grant goes to the source that did not win the most recent contended grant.
  - The RR pointer updates only on contended grants.
- Output stage (1-cycle latency): on a grant, at the next edge rf_write_en_out <= (granted rd != 0), rf_rd_out <= granted rd, rf_write_data_out <= granted data. With no grant, rf_write_en_out <= 0 and rd/data hold.
- x0: a write-back to rd = 0 is accepted and dropped, with no write enable.
- Scoreboard clear: bit rf_rd_out clears at the edge where rf_write_en_out = 1, which is the same edge the register file commits the write. Data is therefore readable on the following cycle.
- Scoreboard set: bit issue_rd_in sets on an issue handshake with issue_rd_in != 0. Bit 0 is never set.
- issue_ready_out = !reset && !busy[rs1] && !busy[rs2] && !busy[rd]. busy[0] is always 0.
- No forwarding: a busy bit being cleared this cycle still stalls issue. Minimum RAW distance is one bubble after rf_write_en_out.
- Set and clear of the same bit in one cycle is impossible, because issue requires rd not busy.
- A write-back to a non-busy rd != 0 is a protocol error. Bench assertion only; the write proceeds.
- Total latency from request grant to data readable: 2 edges.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, with mem over alu. The RR pointer is not instantiated, and alu_ready_out = alu_valid_in && !mem_valid_in && !reset.

Decomposition:
- Package regfile_pkg:
  - REG_ADDR_WIDTH = 5, GEN_REG_COUNT = 32.
  - enum wb_src_e {WB_SRC_ALU, WB_SRC_MEM}.
  - wb_req_t struct {valid, rd, data}, parameterised by width via the package constant of default width.
- Sub-module wb_rr_arbiter: 2-way arbiter with pointer state, producing a grant vector and a wb_src_e select. Its pointer logic is inside WB_ROUND_ROBIN_EN.
- Scoreboard and output stage stay in the top module.

Test Plan:
- Reset then idle:
  - busy_out = 0, rf_write_en_out = 0, all readies 0 during reset.
  - issue_ready_out = 1 for rs1 = 1, rs2 = 2, rd = 3 after reset.
- Issue rd = 5, then issue with rs1 = 5: second issue_ready_out = 0. Then ALU writes rd = 5, data = 0xDEAD:
  - rf_write_en_out = 1 with rf_rd_out = 5 one cycle after grant.
  - busy[5] clears the next edge and issue_ready_out rises.
- ALU and mem both valid for 4 cycles with RR enabled: grant order alu, mem, alu, mem. With the macro off: mem every cycle while mem_valid_in = 1.
- mem write-back with rd = 0, data = 0xFFFF: mem_ready_out = 1, rf_write_en_out stays 0, busy_out unchanged.
- Issue rd = 7 (busy[7] = 1), then assert reset while an ALU write to rd = 7 is in the output stage: after reset, busy_out = 0 and rf_write_en_out = 0.
- Issue rd = 9, then issue rd = 9 again before write-back (WAW): second issue stalls until the cycle after rf_write_en_out with rf_rd_out = 9.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
// The write-back request payload is sized at the default register data width.
package regfile_pkg;

    localparam int unsigned REG_ADDR_WIDTH         = 5;
    localparam int unsigned GEN_REG_COUNT          = 32;
    localparam int unsigned REG_DATA_WIDTH_POW_DEF = 6;
    localparam int unsigned REG_DATA_WIDTH_DEF     = 1 << REG_DATA_WIDTH_POW_DEF;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                          valid;
        logic [REG_ADDR_WIDTH-1:0]     rd;
        logic [REG_DATA_WIDTH_DEF-1:0] data;
    } wb_req_t;

    function automatic wb_src_e wb_src_other(input wb_src_e src);
        return (src == WB_SRC_ALU) ? WB_SRC_MEM : WB_SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way write-back arbiter (ALU vs load unit), one grant per cycle.
// WB_ROUND_ROBIN_EN selects round-robin on contention; otherwise mem has fixed priority.
module wb_rr_arbiter
    import regfile_pkg::*;
(
`ifdef WB_ROUND_ROBIN_EN
    input  logic       clk_in,
    input  logic       reset,
`endif
    input  logic       alu_valid,
    input  logic       mem_valid,
    output logic [1:0] grant_c,
    output wb_src_e    sel_c
);

`ifdef WB_ROUND_ROBIN_EN
    // ptr_q names the source that wins the next contended cycle
    wb_src_e ptr_q;
    wb_src_e ptr_d;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            ptr_q <= WB_SRC_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        sel_c   = WB_SRC_ALU;
        grant_c = '0;
        if (alu_valid && mem_valid) begin
            sel_c = ptr_q;
            ptr_d = wb_src_other(ptr_q);
        end else if (mem_valid) begin
            sel_c = WB_SRC_MEM;
        end
        grant_c[0] = alu_valid && (sel_c == WB_SRC_ALU);
        grant_c[1] = mem_valid && (sel_c == WB_SRC_MEM);
    end
`else
    always_comb begin
        sel_c      = mem_valid ? WB_SRC_MEM : WB_SRC_ALU;
        grant_c    = '0;
        grant_c[0] = alu_valid && !mem_valid;
        grant_c[1] = mem_valid;
    end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: arbitrates ALU/load write-backs onto the single
// write port through a registered stage and keeps a per-register pending-write scoreboard.
// Optional round-robin arbitration via WB_ROUND_ROBIN_EN (default: mem over alu priority).
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter  int unsigned REG_DATA_WIDTH_POW = 6,
    localparam int unsigned REG_DATA_WIDTH     = 1 << REG_DATA_WIDTH_POW
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      issue_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd_in,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs1_in,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs2_in,
    output logic                      issue_ready_out,
    input  logic                      alu_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd_in,
    input  logic [REG_DATA_WIDTH-1:0] alu_data_in,
    output logic                      alu_ready_out,
    input  logic                      mem_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_in,
    input  logic [REG_DATA_WIDTH-1:0] mem_data_in,
    output logic                      mem_ready_out,
    output logic                      rf_write_en_out,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd_out,
    output logic [REG_DATA_WIDTH-1:0] rf_write_data_out,
    output logic [GEN_REG_COUNT-1:0]  busy_out
);

    logic [GEN_REG_COUNT-1:0] busy_q;
    logic [GEN_REG_COUNT-1:0] busy_d;
    wb_req_t                  alu_req;
    wb_req_t                  mem_req;
    wb_req_t                  sel_req;
    logic [1:0]               grant_c;
    wb_src_e                  sel_c;
    logic                     issue_fire_c;
    logic                     wb_fire_c;

    // Requests are masked during reset so no grant can be produced
    always_comb begin
        alu_req = '{valid: alu_valid_in && !reset, rd: alu_rd_in,
                    data: REG_DATA_WIDTH_DEF'(alu_data_in)};
        mem_req = '{valid: mem_valid_in && !reset, rd: mem_rd_in,
                    data: REG_DATA_WIDTH_DEF'(mem_data_in)};
        sel_req = (sel_c == WB_SRC_MEM) ? mem_req : alu_req;
    end

    wb_rr_arbiter u_arb (
`ifdef WB_ROUND_ROBIN_EN
        .clk_in    (clk_in),
        .reset     (reset),
`endif
        .alu_valid (alu_req.valid),
        .mem_valid (mem_req.valid),
        .grant_c   (grant_c),
        .sel_c     (sel_c)
    );

    assign alu_ready_out = grant_c[0];
    assign mem_ready_out = grant_c[1];
    assign wb_fire_c     = sel_req.valid;

    // No forwarding: a bit being cleared this cycle still stalls issue
    assign issue_ready_out = !reset && !busy_q[issue_rs1_in]
                             && !busy_q[issue_rs2_in] && !busy_q[issue_rd_in];
    assign issue_fire_c    = issue_valid_in && issue_ready_out;

    always_comb begin
        busy_d = busy_q;
        if (rf_write_en_out) begin
            busy_d[rf_rd_out] = 1'b0;
        end
        if (issue_fire_c && (issue_rd_in != '0)) begin
            busy_d[issue_rd_in] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_out = busy_q;

    // Registered write port; writes to x0 are accepted but never enabled
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rf_write_en_out   <= 1'b0;
            rf_rd_out         <= '0;
            rf_write_data_out <= '0;
        end else if (wb_fire_c) begin
            rf_write_en_out   <= (sel_req.rd != '0);
            rf_rd_out         <= sel_req.rd;
            rf_write_data_out <= REG_DATA_WIDTH'(sel_req.data);
        end else begin
            rf_write_en_out   <= 1'b0;
        end
    end

endmodule
